// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Registers the chosen operands, captures the ALU result, and holds the response until accepted.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter logic [3:0]  MAX_OP     = 4'b0101
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic [3:0]            req0_op,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic [3:0]            req1_op,

  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  resp_zero,
  output logic                  resp_illegal,

  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_control,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_zero
);

  typedef enum logic [1:0] {StIdle, StExec, StHold} stateT;

  stateT                 stateQ;
  logic                  lastGrantQ;
  logic                  idQ;
  logic                  illegalQ;
  logic [DATA_WIDTH-1:0] aluAQ;
  logic [DATA_WIDTH-1:0] aluBQ;
  logic [3:0]            aluControlQ;
  logic                  respValidQ;
  logic                  respIdQ;
  logic [DATA_WIDTH-1:0] respResultQ;
  logic                  respZeroQ;
  logic                  respIllegalQ;

  logic                  anyValid;
  logic                  grantId;
  logic                  acceptIdle;
  logic [DATA_WIDTH-1:0] selA;
  logic [DATA_WIDTH-1:0] selB;
  logic [3:0]            selOp;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    anyValid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grantId = ~lastGrantQ;
    end else begin
      grantId = req1_valid;
    end
    selA  = grantId ? req1_a  : req0_a;
    selB  = grantId ? req1_b  : req0_b;
    selOp = grantId ? req1_op : req0_op;
    // Reset wins over a grant, so never signal acceptance while it is asserted.
    acceptIdle = (stateQ == StIdle) && !reset;
  end

  assign req0_ready = acceptIdle && req0_valid && !grantId;
  assign req1_ready = acceptIdle && req1_valid &&  grantId;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ       <= StIdle;
      lastGrantQ   <= 1'b1;
      idQ          <= 1'b0;
      illegalQ     <= 1'b0;
      aluAQ        <= '0;
      aluBQ        <= '0;
      aluControlQ  <= 4'b0000;
      respValidQ   <= 1'b0;
      respIdQ      <= 1'b0;
      respResultQ  <= '0;
      respZeroQ    <= 1'b0;
      respIllegalQ <= 1'b0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (anyValid) begin
            aluAQ      <= selA;
            aluBQ      <= selB;
            idQ        <= grantId;
            lastGrantQ <= grantId;
            // Out-of-range codes run as the no-op and are flagged in the response.
            if (selOp > MAX_OP) begin
              aluControlQ <= 4'b0000;
              illegalQ    <= 1'b1;
            end else begin
              aluControlQ <= selOp;
              illegalQ    <= 1'b0;
            end
            stateQ <= StExec;
          end
        end
        StExec: begin
          respResultQ  <= alu_result;
          respZeroQ    <= alu_zero;
          respIdQ      <= idQ;
          respIllegalQ <= illegalQ;
          respValidQ   <= 1'b1;
          aluControlQ  <= 4'b0000;
          stateQ       <= StHold;
        end
        StHold: begin
          if (resp_ready) begin
            respValidQ <= 1'b0;
            stateQ     <= StIdle;
          end
        end
        default: stateQ <= StIdle;
      endcase
    end
  end

  assign alu_a        = aluAQ;
  assign alu_b        = aluBQ;
  assign alu_control  = aluControlQ;
  assign resp_valid   = respValidQ;
  assign resp_id      = respIdQ;
  assign resp_result  = respResultQ;
  assign resp_zero    = respZeroQ;
  assign resp_illegal = respIllegalQ;

  // A pending response must not change until the consumer takes it.
  assert property (@(posedge clk) disable iff (reset)
    (respValidQ && !resp_ready) |=> (respValidQ && $stable(respResultQ) && $stable(respIdQ)
                                     && $stable(respZeroQ) && $stable(respIllegalQ)));

  assert property (@(posedge clk) !(req0_ready && req1_ready));

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single combinational ALU between two requesters, for example a PC-increment path (requester 0) and the execute stage (requester 1).
- Arbitrates between them round-robin and registers the operands that drive the ALU.
- Captures the ALU result and zero flag into a response register, then holds the response until the consumer accepts it.
- Sits between the issue logic and the ALU. The ALU remains unmodified and purely combinational.

Parameters:
- DATA_WIDTH, 16, operand/result width; must equal registerDataWidth.
- MAX_OP, 4'b0101, highest legal ALU control code.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  DATA_WIDTH  operand a
- req0_b  in  DATA_WIDTH  operand b
- req0_op  in  4  ALU control code
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0
- resp_valid  out  1  response available
- resp_ready  in  1  consumer accepts response
- resp_id  out  1  requester index (0/1) of response
- resp_result  out  DATA_WIDTH  captured ALU result
- resp_zero  out  1  captured ALU zero flag
- resp_illegal  out  1  op exceeded MAX_OP
- alu_a  out  DATA_WIDTH  to ALU a
- alu_b  out  DATA_WIDTH  to ALU b
- alu_control  out  4  to ALU aluControl
- alu_result  in  DATA_WIDTH  from ALU aluResult
- alu_zero  in  1  from ALU zeroFlag

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- On reset:
  - state = IDLE and last_grant = 1, so requester 0 wins the first tie.
  - resp_valid, resp_id, resp_result, resp_zero and resp_illegal = 0.
  - alu_a, alu_b and alu_control = 0.
- FSM states: IDLE, EXEC, HOLD.
- IDLE, grant selection:
  - Only one valid: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
  - reqN_ready = (state==IDLE) && reqN_valid && granted==N. It is combinational on both valids, so requesters must not derive valid from ready.
- IDLE, on grant:
  - Register a, b, op and id; update last_grant.
  - If op > MAX_OP, register op as 4'b0000 and set illegal_q = 1.
  - Go to EXEC.
- EXEC (exactly 1 cycle):
  - alu_a, alu_b and alu_control drive the registered values.
  - At the clock edge, capture alu_result and alu_zero into resp_result and resp_zero; copy id and illegal_q; set resp_valid = 1; go to HOLD.
- IDLE and HOLD: alu_control = 4'b0000 (no-op); alu_a and alu_b hold their last values.
- HOLD:
  - resp_* held stable while resp_valid && !resp_ready.
  - On resp_valid && resp_ready: resp_valid = 0 next cycle; go to IDLE.
  - No new request is accepted in HOLD.
- Latency and throughput:
  - Accept in cycle N; resp_valid high from cycle N+2.
  - Minimum 3 cycles per operation when resp_ready is tied high.
- Zero flag: resp_zero is the ALU's zeroFlag passed through unchanged, i.e. (a-b)==0 regardless of op.
- Illegal op: the response is still produced. resp_illegal = 1 and the result comes from the no-op; the ALU produces 0 for code 0000.
- Reset mid-operation (EXEC or HOLD): the transaction is discarded, no response is produced, and all reset values apply next cycle.
- A request that is not granted while its valid stays high keeps its operands stable; the arbiter never drops a held request.

Test Plan:
- Single request: req0 a=16'h0005, b=16'h0003, op=0001 → req0_ready in cycle 0. Response 2 cycles later: resp_result=16'h0008, resp_zero=0, resp_id=0, resp_illegal=0.
- Zero flag: req1 a=b=16'h00AA, op=0010 → resp_result=0, resp_zero=1, resp_id=1.
- Contention after reset: both valid with ops 0001 and 0010 → req0 served first, then req1. Then re-assert both → req0 is served next, because last_grant is now 1, so the not-last requester is 0. Grants strictly alternate while both remain valid.
- Backpressure: resp_ready=0 for 5 cycles → resp_* stable, both req_ready stay 0. Raise resp_ready → resp_valid falls next cycle, and the next grant is in the following cycle.
- Illegal op: op=4'b1001, a=7, b=7 → alu_control=0000 during EXEC. Response: resp_result=0, resp_illegal=1, resp_zero=1.
- Reset in HOLD: assert reset while resp_valid=1 → resp_valid=0 next cycle, no response for the discarded op, and state is IDLE with req0 winning the next tie.
